// File: rtl/aes_arbiter.sv
// Round-robin arbiter sharing one pipelined AES-128 core among NUM_REQ requesters.
// Tracks issued work in an id FIFO, buffers results in an in-order response FIFO,
// and sequences key changes so a new key is applied only while the core is empty.
module aes_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic [NUM_REQ-1:0][127:0]       i_req_data,
    output logic [NUM_REQ-1:0]              o_rsp_valid,
    input  logic [NUM_REQ-1:0]              i_rsp_ready,
    output logic [127:0]                    o_rsp_data,
    input  logic [127:0]                    i_key_in,
    input  logic                            i_key_load,
    output logic                            o_key_busy,
    output logic                            o_core_data_valid,
    output logic [127:0]                    o_core_plain_text,
    output logic                            o_core_key_valid,
    output logic [127:0]                    o_core_cipher_key,
    input  logic                            i_core_valid_out,
    input  logic [127:0]                    i_core_cipher_text,
    output logic [$clog2(DEPTH):0]          o_inflight,
    output logic                            o_err_spurious
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    // Arbitration and issue tracking
    logic [IW-1:0]  r_rr_ptr;
    logic [CW-1:0]  r_inflight;
    logic [IW-1:0]  r_id_mem [DEPTH];
    logic [PW-1:0]  r_id_wr;
    logic [PW-1:0]  r_id_rd;

    // Response FIFO
    logic [IW-1:0]  r_rsp_id_mem [DEPTH];
    logic [127:0]   r_rsp_ct_mem [DEPTH];
    logic [PW-1:0]  r_rsp_wr;
    logic [PW-1:0]  r_rsp_rd;
    logic [CW-1:0]  r_rsp_count;

    // Key sequencing
    logic           r_key_busy;
    logic [127:0]   r_key_stage;
    logic [127:0]   r_key;
    logic           r_key_valid;
    logic           r_err;

    logic [IW-1:0]  w_grant;
    logic [IW-1:0]  w_cand;
    logic           w_any;
    logic [CW:0]    w_total;
    logic           w_can_issue;
    logic           w_issue;
    logic           w_ret;
    logic           w_spur;
    logic           w_rsp_nonempty;
    logic [IW-1:0]  w_rsp_id;
    logic           w_rsp_pop;
    logic           w_key_swap;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IW'(sum);
    endfunction

    // Round-robin search starting at r_rr_ptr; first valid requester wins
    always_comb begin
        w_grant = '0;
        w_cand  = '0;
        w_any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = wrap_add(r_rr_ptr, k);
            if (!w_any && i_req_valid[w_cand]) begin
                w_any   = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // Credit check, issue strobe and handshake decode
    always_comb begin
        // Pops this cycle are deliberately not credited to keep the path short
        w_total        = {1'b0, r_inflight} + {1'b0, r_rsp_count};
        // The key-valid cycle is also blocked so the first new-key issue follows it
        w_can_issue    = !i_rst && (w_total < LIMIT) && !r_key_busy && !r_key_valid;
        w_issue        = w_any && w_can_issue;
        w_ret          = i_core_valid_out && (r_inflight != '0);
        w_spur         = i_core_valid_out && (r_inflight == '0);
        w_rsp_nonempty = (r_rsp_count != '0);
        w_rsp_id       = r_rsp_id_mem[r_rsp_rd];
        w_rsp_pop      = w_rsp_nonempty && i_rsp_ready[w_rsp_id];
        w_key_swap     = r_key_busy && (r_inflight == '0);

        o_req_ready = '0;
        if (w_issue) o_req_ready[w_grant] = 1'b1;

        o_rsp_valid = '0;
        if (w_rsp_nonempty) o_rsp_valid[w_rsp_id] = 1'b1;

        o_core_data_valid = w_issue;
        o_core_plain_text = w_issue ? i_req_data[w_grant] : '0;
    end

    assign o_rsp_data        = r_rsp_ct_mem[r_rsp_rd];
    assign o_key_busy        = r_key_busy;
    assign o_core_key_valid  = r_key_valid;
    assign o_core_cipher_key = r_key;
    assign o_inflight        = r_inflight;
    assign o_err_spurious    = r_err;

    // Round-robin pointer, in-flight counter and id FIFO pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr   <= '0;
            r_inflight <= '0;
            r_id_wr    <= '0;
            r_id_rd    <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= wrap_add(w_grant, 1);
                r_id_wr  <= r_id_wr + PW'(1);
            end
            if (w_ret) r_id_rd <= r_id_rd + PW'(1);
            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the matching FIFO is empty
    always_ff @(posedge i_clk) begin
        if (w_issue) r_id_mem[r_id_wr] <= w_grant;
        if (w_ret) begin
            r_rsp_id_mem[r_rsp_wr] <= r_id_mem[r_id_rd];
            r_rsp_ct_mem[r_rsp_wr] <= i_core_cipher_text;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_wr    <= '0;
            r_rsp_rd    <= '0;
            r_rsp_count <= '0;
        end else begin
            if (w_ret)     r_rsp_wr <= r_rsp_wr + PW'(1);
            if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + PW'(1);
            case ({w_ret, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + CW'(1);
                2'b01:   r_rsp_count <= r_rsp_count - CW'(1);
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

    // Key staging and swap once the core has drained
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key_busy  <= 1'b0;
            r_key_stage <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_key_swap;
            if (w_key_swap) r_key <= r_key_stage;
            // A load coinciding with a swap keeps busy set for a second swap
            if (i_key_load) begin
                r_key_stage <= i_key_in;
                r_key_busy  <= 1'b1;
            end else if (w_key_swap) begin
                r_key_busy  <= 1'b0;
            end
        end
    end

    // Sticky flag for core results arriving with nothing outstanding
    always_ff @(posedge i_clk) begin
        if (i_rst) r_err <= 1'b0;
        else if (w_spur) r_err <= 1'b1;
    end

endmodule

// File: tb/tb_aes_arbiter.sv
// Self-checking bench for aes_arbiter: XOR-cipher core model with latency 3 and an
// in-order response scoreboard.
module tb_aes_arbiter;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_ready;
    logic [1:0][127:0]  req_data = '0;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready = '0;
    logic [127:0]       rsp_data;
    logic [127:0]       key_in = '0;
    logic               key_load = 1'b0;
    logic               key_busy;
    logic               core_data_valid;
    logic [127:0]       core_plain_text;
    logic               core_key_valid;
    logic [127:0]       core_cipher_key;
    logic               core_valid_out;
    logic [127:0]       core_cipher_text;
    logic [2:0]         inflight;
    logic               err_spurious;

    int errors = 0;
    int checks = 0;
    int exp_ptr = 0;
    logic [127:0] tb_key = '0;
    int exp_id_q[$];
    logic [127:0] exp_data_q[$];

    // Core model
    logic [2:0]   pv = '0;
    logic [127:0] pd0 = '0, pd1 = '0, pd2 = '0;
    logic         inj = 1'b0;
    logic [127:0] inj_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pv  <= {pv[1:0], core_data_valid};
        pd0 <= core_plain_text ^ core_cipher_key;
        pd1 <= pd0;
        pd2 <= pd1;
    end

    assign core_valid_out   = pv[2] | inj;
    assign core_cipher_text = pv[2] ? pd2 : inj_data;

    aes_arbiter #(.NUM_REQ(2), .DEPTH(4)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_data         (req_data),
        .o_rsp_valid        (rsp_valid),
        .i_rsp_ready        (rsp_ready),
        .o_rsp_data         (rsp_data),
        .i_key_in           (key_in),
        .i_key_load         (key_load),
        .o_key_busy         (key_busy),
        .o_core_data_valid  (core_data_valid),
        .o_core_plain_text  (core_plain_text),
        .o_core_key_valid   (core_key_valid),
        .o_core_cipher_key  (core_cipher_key),
        .i_core_valid_out   (core_valid_out),
        .i_core_cipher_text (core_cipher_text),
        .o_inflight         (inflight),
        .o_err_spurious     (err_spurious)
    );

    // Scoreboard: every response handshake pops and compares
    int           mon_id;
    logic [127:0] mon_d;
    logic [1:0]   mon_oh;
    always @(negedge clk) begin
        if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
            checks++;
            if (exp_id_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, required no response",
                         rsp_valid, rsp_data);
            end else begin
                mon_id = exp_id_q.pop_front();
                mon_d  = exp_data_q.pop_front();
                mon_oh = 2'b01 << mon_id;
                if (rsp_valid !== mon_oh || rsp_data !== mon_d) begin
                    errors++;
                    $display("FAIL rsp_scoreboard: valid=%b data=%h, required valid=%b data=%h",
                             rsp_valid, rsp_data, mon_oh, mon_d);
                end
            end
        end
    end

    function automatic int exp_grant(input logic [1:0] v, input int ptr);
        for (int k = 0; k < 2; k++) begin
            int i;
            i = (ptr + k) % 2;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_exp(input int id, input logic [127:0] d);
        exp_id_q.push_back(id);
        exp_data_q.push_back(d);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_id_q.size() != 0 || inflight != 3'd0) && c < 40) begin
            tick();
            c++;
        end
        checks++;
        if (exp_id_q.size() != 0 || inflight != 3'd0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses pending, inflight=%0d, required 0 and 0",
                     exp_id_q.size(), inflight);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        sample();
        checks += 5;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b, required 00", req_ready);
        end
        if (core_data_valid !== 1'b0 || core_key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_core_strobes: got dv=%b kv=%b, required 0 0",
                               core_data_valid, core_key_valid);
        end
        if (rsp_valid !== 2'b00 || inflight !== 3'd0) begin
            errors++; $display("FAIL reset_rsp_inflight: got %b %0d, required 00 0",
                               rsp_valid, inflight);
        end
        if (key_busy !== 1'b0 || err_spurious !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b err=%b, required 0 0",
                               key_busy, err_spurious);
        end
        if (core_cipher_key !== 128'd0) begin
            errors++; $display("FAIL reset_key: got %h, required 0", core_cipher_key);
        end
        tick();
        req_valid = 2'b00;
        rst = 1'b0;
        sample();
        checks++;
        if (req_ready !== 2'b00 || core_data_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b dv=%b, required 00 0",
                               req_ready, core_data_valid);
        end
        exp_ptr = 0;
        tb_key = '0;
        tick();
    endtask

    task automatic test_key_init(input logic [127:0] k);
        key_in = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_in = rnd128();
        sample();
        checks++;
        if (key_busy !== 1'b1 || core_key_valid !== 1'b0) begin
            errors++; $display("FAIL key_init_busy: got busy=%b kv=%b, required 1 0",
                               key_busy, core_key_valid);
        end
        tick();
        sample();
        checks++;
        if (core_key_valid !== 1'b1 || core_cipher_key !== k || key_busy !== 1'b0) begin
            errors++; $display("FAIL key_init_apply: got kv=%b key=%h busy=%b, required 1 %h 0",
                               core_key_valid, core_cipher_key, key_busy, k);
        end
        tick();
        sample();
        checks++;
        if (core_key_valid !== 1'b0) begin
            errors++; $display("FAIL key_init_pulse: got kv=%b, required 0", core_key_valid);
        end
        tb_key = k;
        tick();
    endtask

    task automatic test_single();
        logic [127:0] d;
        logic [1:0]   oh;
        int g;
        d = {16{8'h11}};
        req_data[0] = d;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        sample();
        g = exp_grant(req_valid, exp_ptr);
        oh = 2'b01 << g;
        checks++;
        if (req_ready !== oh || core_data_valid !== 1'b1 || core_plain_text !== d) begin
            errors++; $display("FAIL single_issue: got ready=%b dv=%b pt=%h, required %b 1 %h",
                               req_ready, core_data_valid, core_plain_text, oh, d);
        end
        push_exp(g, d ^ tb_key);
        exp_ptr = (g + 1) % 2;
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= 3; c++) begin
            sample();
            checks++;
            if (core_valid_out !== (c == 3)) begin
                errors++; $display("FAIL single_latency: cycle %0d core_valid_out=%b, required %b",
                                   c, core_valid_out, (c == 3));
            end
            if (c == 1) begin
                checks++;
                if (inflight !== 3'd1) begin
                    errors++; $display("FAIL single_inflight: got %0d, required 1", inflight);
                end
            end
            tick();
        end
        wait_drain();
    endtask

    task automatic test_contention();
        int grants, cyc, g;
        logic [1:0] oh;
        logic issued;
        grants = 0;
        cyc = 0;
        rsp_ready = 2'b11;
        req_data[0] = rnd128();
        req_data[1] = rnd128();
        req_valid = 2'b11;
        while (grants < 6 && cyc < 40) begin
            sample();
            issued = 1'b0;
            g = 0;
            if (req_ready !== 2'b00) begin
                g = exp_grant(req_valid, exp_ptr);
                oh = 2'b01 << g;
                checks++;
                if (req_ready !== oh || core_plain_text !== req_data[g]) begin
                    errors++; $display("FAIL contention_grant: got ready=%b pt=%h, required %b %h",
                                       req_ready, core_plain_text, oh, req_data[g]);
                end
                push_exp(g, req_data[g] ^ tb_key);
                exp_ptr = (g + 1) % 2;
                grants++;
                issued = 1'b1;
            end
            tick();
            if (issued) req_data[g] = rnd128();
            cyc++;
        end
        checks++;
        if (grants != 6) begin
            errors++; $display("FAIL contention_timeout: got %0d grants, required 6", grants);
        end
        req_valid = 2'b00;
        wait_drain();
    endtask

    task automatic test_credit();
        int accepts;
        logic issued;
        accepts = 0;
        rsp_ready = 2'b00;
        req_data[0] = rnd128();
        req_valid = 2'b01;
        for (int c = 0; c < 12; c++) begin
            sample();
            issued = 1'b0;
            if (req_ready[0] === 1'b1) begin
                push_exp(0, req_data[0] ^ tb_key);
                exp_ptr = 1;
                accepts++;
                issued = 1'b1;
            end
            tick();
            if (issued) req_data[0] = rnd128();
        end
        sample();
        checks += 2;
        if (accepts != 4) begin
            errors++; $display("FAIL credit_accepts: got %0d, required 4", accepts);
        end
        if (req_ready !== 2'b00 || inflight !== 3'd0 || rsp_valid !== 2'b01) begin
            errors++; $display("FAIL credit_full: got ready=%b inflight=%0d rsp=%b, required 00 0 01",
                               req_ready, inflight, rsp_valid);
        end
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (rsp_valid !== ((c < 4) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL credit_drain: cycle %0d rsp_valid=%b, required %b",
                                   c, rsp_valid, ((c < 4) ? 2'b01 : 2'b00));
            end
            tick();
        end
        req_valid = 2'b01;
        sample();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL credit_reopen: got %b, required 01", req_ready);
        end
        push_exp(0, req_data[0] ^ tb_key);
        exp_ptr = 1;
        tick();
        req_valid = 2'b00;
        wait_drain();
    endtask

    task automatic test_hol();
        rsp_ready = 2'b00;
        req_data[1] = rnd128();
        req_data[0] = rnd128();
        req_valid = 2'b10;
        sample();
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL hol_grant1: got %b, required 10", req_ready);
        end
        push_exp(1, req_data[1] ^ tb_key);
        exp_ptr = 0;
        tick();
        req_valid = 2'b01;
        sample();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL hol_grant0: got %b, required 01", req_ready);
        end
        push_exp(0, req_data[0] ^ tb_key);
        exp_ptr = 1;
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        repeat (6) tick();
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (rsp_valid !== 2'b10) begin
                errors++; $display("FAIL hol_block: got rsp_valid=%b, required 10", rsp_valid);
            end
            tick();
        end
        rsp_ready = 2'b11;
        wait_drain();
    endtask

    task automatic test_key_change(input logic [127:0] k);
        int g;
        logic [1:0] oh;
        logic found;
        rsp_ready = 2'b11;
        req_data[0] = rnd128();
        req_data[1] = rnd128();
        req_valid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            sample();
            g = exp_grant(req_valid, exp_ptr);
            oh = 2'b01 << g;
            checks++;
            if (req_ready !== oh) begin
                errors++; $display("FAIL keychg_issue: got %b, required %b", req_ready, oh);
            end
            push_exp(g, req_data[g] ^ tb_key);
            exp_ptr = (g + 1) % 2;
            tick();
            req_data[g] = rnd128();
        end
        req_valid = 2'b00;
        key_in = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        req_valid = 2'b01;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            sample();
            if (core_key_valid === 1'b1) begin
                found = 1'b1;
            end else begin
                checks++;
                if (req_ready !== 2'b00) begin
                    errors++; $display("FAIL keychg_hold: got ready=%b, required 00", req_ready);
                end
                tick();
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL keychg_timeout: got no core_key_valid, required one pulse");
        end else if (core_cipher_key !== k || req_ready !== 2'b00 || inflight !== 3'd0) begin
            errors++; $display("FAIL keychg_apply: got key=%h ready=%b inflight=%0d, required %h 00 0",
                               core_cipher_key, req_ready, inflight, k);
        end
        tb_key = k;
        tick();
        sample();
        checks++;
        if (req_ready !== 2'b01 || core_key_valid !== 1'b0 || core_plain_text !== req_data[0]) begin
            errors++; $display("FAIL keychg_resume: got ready=%b kv=%b, required 01 0",
                               req_ready, core_key_valid);
        end
        push_exp(0, req_data[0] ^ tb_key);
        exp_ptr = 1;
        tick();
        req_valid = 2'b00;
        wait_drain();
    endtask

    task automatic test_spurious();
        sample();
        checks++;
        if (err_spurious !== 1'b0) begin
            errors++; $display("FAIL spur_pre: got %b, required 0", err_spurious);
        end
        tick();
        inj_data = rnd128();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        sample();
        checks++;
        if (err_spurious !== 1'b1 || inflight !== 3'd0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL spur_flag: got err=%b inflight=%0d rsp=%b, required 1 0 00",
                               err_spurious, inflight, rsp_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        tick();
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_id_q.delete();
        exp_data_q.delete();
        exp_ptr = 0;
        tb_key = '0;
        sample();
        checks += 2;
        if (inflight !== 3'd0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL midrst_clear: got inflight=%0d rsp=%b ready=%b, required 0 00 00",
                               inflight, rsp_valid, req_ready);
        end
        if (key_busy !== 1'b0 || core_cipher_key !== 128'd0 || err_spurious !== 1'b0
            || core_key_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_key: got busy=%b key=%h err=%b kv=%b, required 0 0 0 0",
                               key_busy, core_cipher_key, err_spurious, core_key_valid);
        end
        repeat (4) tick();
        sample();
        checks++;
        if (err_spurious !== 1'b1 || rsp_valid !== 2'b00 || inflight !== 3'd0) begin
            errors++; $display("FAIL midrst_stale: got err=%b rsp=%b inflight=%0d, required 1 00 0",
                               err_spurious, rsp_valid, inflight);
        end
        tick();
        req_valid = 2'b11;
        sample();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL midrst_rrptr: got %b, required 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_key_init(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        test_single();
        test_contention();
        test_credit();
        test_hol();
        test_key_change(128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678);
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
